pong_engine: RTL and testbench



---
 rtl/pong_engine.sv | 240 ++++++++++++++++++++++++
 tb/tb_pong_engine.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_engine.sv
// rtl/pong_engine.sv - Pong game core: paddles, ball, scoring, serve/play/game-over FSM, pixel overlay.
module pong_engine #(
  parameter int         H_RES       = 640,
  parameter int         V_RES       = 480,
  parameter int         POS_W       = 12,
  parameter int         PAD_W       = 20,
  parameter int         PAD_H       = 100,
  parameter int         BALL_SIZE   = 20,
  parameter int         PAD_L_X     = 100,
  parameter int         PAD_R_X     = 500,
  parameter int         PAD_VEL     = 10,
  parameter int         BALL_VEL    = 3,
  parameter int         SERVE_DELAY = 60,
  parameter int         SCORE_MAX   = 9,
  parameter logic [7:0] OBJ_INDEX   = 8'h02
) (
  input  logic             iVGA_CLK,
  input  logic             iRST_n,
  input  logic             frame_tick,
  input  logic             restart,
  input  logic             pL_moveup,
  input  logic             pL_movedown,
  input  logic             pR_moveup,
  input  logic             pR_movedown,
  input  logic [POS_W-1:0] x_addr,
  input  logic [POS_W-1:0] y_addr,
  input  logic [7:0]       bg_index,
  output logic [7:0]       color_index,
  output logic [POS_W-1:0] pL_y,
  output logic [POS_W-1:0] pR_y,
  output logic [POS_W-1:0] ball_x,
  output logic [POS_W-1:0] ball_y,
  output logic [3:0]       score_l,
  output logic [3:0]       score_r,
  output logic [1:0]       state
);

  typedef logic signed [POS_W:0] spos_t;
  typedef enum logic [1:0] {ST_SERVE = 2'd0, ST_PLAY = 2'd1, ST_OVER = 2'd2} state_t;

  localparam int    CNT_W      = $clog2(SERVE_DELAY + 1);
  localparam spos_t ZERO       = '0;
  localparam spos_t PAD_Y_MAX  = spos_t'(V_RES - PAD_H);
  localparam spos_t BALL_Y_MAX = spos_t'(V_RES - BALL_SIZE);
  localparam spos_t BALL_X_MAX = spos_t'(H_RES - BALL_SIZE);
  localparam spos_t S_BALL     = spos_t'(BALL_SIZE);
  localparam spos_t S_PAD_W    = spos_t'(PAD_W);
  localparam spos_t S_PAD_H    = spos_t'(PAD_H);
  localparam spos_t S_L_X      = spos_t'(PAD_L_X);
  localparam spos_t S_R_X      = spos_t'(PAD_R_X);
  localparam spos_t S_BV       = spos_t'(BALL_VEL);
  localparam logic [POS_W-1:0] PAD_Y0  = POS_W'((V_RES - PAD_H) / 2);
  localparam logic [POS_W-1:0] BALL_X0 = POS_W'((H_RES - BALL_SIZE) / 2);
  localparam logic [POS_W-1:0] BALL_Y0 = POS_W'((V_RES - BALL_SIZE) / 2);
  localparam logic [POS_W-1:0] L_BOUNCE_X = POS_W'(PAD_L_X + PAD_W);
  localparam logic [POS_W-1:0] R_BOUNCE_X = POS_W'(PAD_R_X - BALL_SIZE);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         sync1_q, sync2_q;
  logic [POS_W-1:0]   pl_y_q, pl_y_d, pr_y_q, pr_y_d;
  logic [POS_W-1:0]   ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic               dx_q, dx_d, dy_q, dy_d, dy_n;
  logic [3:0]         score_l_q, score_l_d, score_r_q, score_r_d;
  logic [7:0]         color_q, color_d;
  spos_t              nx, ny, pl_s, pr_s;
  logic               playing, hit_l, hit_r, pt_l, pt_r;

  // Signed, one bit wider than a coordinate, so moving up past 0 clamps instead of wrapping.
  function automatic logic [POS_W-1:0] step_paddle(input logic [POS_W-1:0] y,
                                                   input logic up_n, input logic dn_n);
    spos_t v;
    v = $signed({1'b0, y});
    if (!up_n && dn_n)      v = v - spos_t'(PAD_VEL);
    else if (up_n && !dn_n) v = v + spos_t'(PAD_VEL);
    if (v < ZERO)           v = ZERO;
    else if (v > PAD_Y_MAX) v = PAD_Y_MAX;
    return v[POS_W-1:0];
  endfunction

  function automatic logic covers(input logic [POS_W-1:0] px, input logic [POS_W-1:0] py,
                                  input logic [POS_W-1:0] ox, input logic [POS_W-1:0] oy,
                                  input int w, input int h);
    return ({1'b0, px} >= {1'b0, ox}) && ({1'b0, px} < {1'b0, ox} + (POS_W+1)'(w)) &&
           ({1'b0, py} >= {1'b0, oy}) && ({1'b0, py} < {1'b0, oy} + (POS_W+1)'(h));
  endfunction

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= ST_SERVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin : ball_path
    playing = frame_tick && !restart && (state_q == ST_PLAY);
    pl_s    = $signed({1'b0, pl_y_q});
    pr_s    = $signed({1'b0, pr_y_q});
    nx      = $signed({1'b0, ball_x_q}) + (dx_q ? S_BV : -S_BV);
    ny      = $signed({1'b0, ball_y_q}) + (dy_q ? S_BV : -S_BV);
    dy_n    = dy_q;
    if (ny <= ZERO) begin
      ny   = ZERO;
      dy_n = ~dy_q;
    end else if (ny >= BALL_Y_MAX) begin
      ny   = BALL_Y_MAX;
      dy_n = ~dy_q;
    end
    hit_l = !dx_q && (nx < S_L_X + S_PAD_W) && (nx + S_BALL > S_L_X) &&
            (ny < pl_s + S_PAD_H) && (ny + S_BALL > pl_s);
    hit_r = dx_q && (nx < S_R_X + S_PAD_W) && (nx + S_BALL > S_R_X) &&
            (ny < pr_s + S_PAD_H) && (ny + S_BALL > pr_s);
    pt_r  = playing && !hit_l && !hit_r && (nx <= ZERO);
    pt_l  = playing && !hit_l && !hit_r && !(nx <= ZERO) && (nx >= BALL_X_MAX);
  end

  always_comb begin : fsm_next
    state_d = state_q;
    cnt_d   = cnt_q;
    if (restart) begin
      state_d = ST_SERVE;
      cnt_d   = '0;
    end else if (frame_tick) begin
      unique case (state_q)
        ST_SERVE: begin
          if (cnt_q == CNT_W'(SERVE_DELAY - 1)) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_PLAY: begin
          if (pt_l)      state_d = (score_l_q == 4'(SCORE_MAX - 1)) ? ST_OVER : ST_SERVE;
          else if (pt_r) state_d = (score_r_q == 4'(SCORE_MAX - 1)) ? ST_OVER : ST_SERVE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin : obj_update
    pl_y_d    = pl_y_q;
    pr_y_d    = pr_y_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    if (restart) begin
      pl_y_d    = PAD_Y0;
      pr_y_d    = PAD_Y0;
      ball_x_d  = BALL_X0;
      ball_y_d  = BALL_Y0;
      dx_d      = 1'b1;
      dy_d      = 1'b1;
      score_l_d = '0;
      score_r_d = '0;
    end else if (frame_tick) begin
      if (state_q != ST_OVER) begin
        pl_y_d = step_paddle(pl_y_q, sync2_q[3], sync2_q[2]);
        pr_y_d = step_paddle(pr_y_q, sync2_q[1], sync2_q[0]);
      end
      if (state_q == ST_PLAY) begin
        ball_y_d = ny[POS_W-1:0];
        dy_d     = dy_n;
        if (hit_l) begin
          ball_x_d = L_BOUNCE_X;
          dx_d     = 1'b1;
        end else if (hit_r) begin
          ball_x_d = R_BOUNCE_X;
          dx_d     = 1'b0;
        end else if (pt_r) begin
          score_r_d = score_r_q + 4'd1;
          ball_x_d  = BALL_X0;
          ball_y_d  = BALL_Y0;
          dx_d      = 1'b1;
        end else if (pt_l) begin
          score_l_d = score_l_q + 4'd1;
          ball_x_d  = BALL_X0;
          ball_y_d  = BALL_Y0;
          dx_d      = 1'b0;
        end else begin
          ball_x_d = nx[POS_W-1:0];
        end
      end
    end
  end

  // Ball drawn over paddles; all objects share one color index.
  always_comb begin : overlay
    color_d = bg_index;
    if (covers(x_addr, y_addr, ball_x_q, ball_y_q, BALL_SIZE, BALL_SIZE) ||
        covers(x_addr, y_addr, POS_W'(PAD_R_X), pr_y_q, PAD_W, PAD_H) ||
        covers(x_addr, y_addr, POS_W'(PAD_L_X), pl_y_q, PAD_W, PAD_H))
      color_d = OBJ_INDEX;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      pl_y_q    <= PAD_Y0;
      pr_y_q    <= PAD_Y0;
      ball_x_q  <= BALL_X0;
      ball_y_q  <= BALL_Y0;
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      score_l_q <= '0;
      score_r_q <= '0;
      color_q   <= '0;
    end else begin
      sync1_q   <= {pL_moveup, pL_movedown, pR_moveup, pR_movedown};
      sync2_q   <= sync1_q;
      pl_y_q    <= pl_y_d;
      pr_y_q    <= pr_y_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      color_q   <= color_d;
    end
  end

  assign color_index = color_q;
  assign pL_y        = pl_y_q;
  assign pR_y        = pr_y_q;
  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pong_engine.sv
// tb/tb_pong_engine.sv - Self-checking bench for pong_engine against a frame-level game model.
module tb_pong_engine;

  localparam int SM    = 2;
  localparam int SERVE = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_tick = 1'b0;
  logic        restart = 1'b0;
  logic        lu = 1'b1, ld = 1'b1, ru = 1'b1, rd = 1'b1;
  logic [11:0] x_addr = '0, y_addr = '0;
  logic [7:0]  bg = '0;
  logic [7:0]  color_index;
  logic [11:0] pL_y, pR_y, ball_x, ball_y;
  logic [3:0]  score_l, score_r;
  logic [1:0]  state;

  pong_engine #(.SCORE_MAX(SM)) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .frame_tick(frame_tick), .restart(restart),
    .pL_moveup(lu), .pL_movedown(ld), .pR_moveup(ru), .pR_movedown(rd),
    .x_addr(x_addr), .y_addr(y_addr), .bg_index(bg), .color_index(color_index),
    .pL_y(pL_y), .pR_y(pR_y), .ball_x(ball_x), .ball_y(ball_y),
    .score_l(score_l), .score_r(score_r), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Game model: plain integers, one call per frame
  int m_pl, m_pr, m_bx, m_by, m_sl, m_sr, m_st, m_ticks;
  bit m_dx, m_dy;

  typedef struct {
    int x;
    int y;
    int bg;
    int exp;
  } pix_t;
  pix_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit ovl(input int a, input int aw, input int b, input int bw);
    return (a < b + bw) && (b < a + aw);
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int pdelta(input bit up_n, input bit dn_n);
    if (!up_n && dn_n) return -10;
    if (up_n && !dn_n) return 10;
    return 0;
  endfunction

  function automatic int m_color(input int px, input int py, input int pbg);
    if ((ovl(px, 1, m_bx, 20) && ovl(py, 1, m_by, 20)) ||
        (ovl(px, 1, 100, 20) && ovl(py, 1, m_pl, 100)) ||
        (ovl(px, 1, 500, 20) && ovl(py, 1, m_pr, 100)))
      return 2;
    return pbg;
  endfunction

  task automatic m_reset();
    m_pl = 190; m_pr = 190; m_bx = 310; m_by = 230;
    m_dx = 1; m_dy = 1; m_sl = 0; m_sr = 0; m_st = 0; m_ticks = 0;
  endtask

  task automatic m_tick(input bit a, input bit b, input bit c, input bit d);
    int nx, ny, old_st;
    bit hl, hr;
    old_st = m_st;
    if (m_st == 1) begin
      nx = m_bx + (m_dx ? 3 : -3);
      ny = m_by + (m_dy ? 3 : -3);
      if (ny <= 0) begin ny = 0; m_dy = !m_dy; end
      else if (ny >= 460) begin ny = 460; m_dy = !m_dy; end
      hl = !m_dx && ovl(nx, 20, 100, 20) && ovl(ny, 20, m_pl, 100);
      hr = m_dx && ovl(nx, 20, 500, 20) && ovl(ny, 20, m_pr, 100);
      m_by = ny;
      if (hl) begin m_bx = 120; m_dx = 1; end
      else if (hr) begin m_bx = 480; m_dx = 0; end
      else if (nx <= 0 || nx >= 620) begin
        if (nx <= 0) begin m_sr++; m_dx = 1; end
        else begin m_sl++; m_dx = 0; end
        m_bx = 310; m_by = 230;
        m_st = (m_sl == SM || m_sr == SM) ? 2 : 0;
        m_ticks = 0;
      end else m_bx = nx;
    end else if (m_st == 0) begin
      m_ticks++;
      if (m_ticks == SERVE) begin m_st = 1; m_ticks = 0; end
    end
    if (old_st != 2) begin
      m_pl = clampi(m_pl + pdelta(a, b), 0, 380);
      m_pr = clampi(m_pr + pdelta(c, d), 0, 380);
    end
  endtask

  task automatic check_state();
    chk("pL_y", pL_y, m_pl);
    chk("pR_y", pR_y, m_pr);
    chk("ball_x", ball_x, m_bx);
    chk("ball_y", ball_y, m_by);
    chk("score_l", score_l, m_sl);
    chk("score_r", score_r, m_sr);
    chk("state", state, m_st);
  endtask

  // Buttons are held 3+ cycles before the tick so the synchronizer has settled.
  task automatic do_tick(input bit a, input bit b, input bit c, input bit d,
                         input bit rs, input int extra);
    int o, bxp, byp, px, py, pb;
    lu = a; ld = b; ru = c; rd = d;
    @(negedge clk);
    o = $urandom_range(0, 2);
    bxp = (o == 0) ? m_bx : (o == 1) ? 100 : 500;
    byp = (o == 0) ? m_by : (o == 1) ? m_pl : m_pr;
    px = bxp + $urandom_range(0, 44) - 12;
    py = byp + $urandom_range(0, 124) - 12;
    if (px < 0) px = 0;
    if (py < 0) py = 0;
    pb = $urandom_range(0, 255);
    x_addr = 12'(px); y_addr = 12'(py); bg = 8'(pb);
    @(negedge clk);
    chk("color_probe", color_index, m_color(px, py, pb));
    @(negedge clk);
    repeat (extra) @(negedge clk);
    frame_tick = 1'b1; restart = rs;
    @(negedge clk);
    frame_tick = 1'b0; restart = 1'b0;
    if (rs) m_reset();
    else m_tick(a, b, c, d);
    check_state();
  endtask

  initial begin
    int n;
    tbl[0]  = '{100, 190, 5, 2};
    tbl[1]  = '{99, 190, 5, 5};
    tbl[2]  = '{120, 190, 5, 5};
    tbl[3]  = '{119, 289, 7, 2};
    tbl[4]  = '{119, 290, 7, 7};
    tbl[5]  = '{100, 189, 7, 7};
    tbl[6]  = '{500, 190, 9, 2};
    tbl[7]  = '{519, 289, 9, 2};
    tbl[8]  = '{520, 200, 9, 9};
    tbl[9]  = '{310, 230, 10, 2};
    tbl[10] = '{329, 249, 10, 2};
    tbl[11] = '{330, 249, 10, 10};
    tbl[12] = '{309, 230, 10, 10};
    tbl[13] = '{0, 0, 51, 51};

    m_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pL_y", pL_y, 190);
    chk("rst_pR_y", pR_y, 190);
    chk("rst_ball_x", ball_x, 310);
    chk("rst_ball_y", ball_y, 230);
    chk("rst_scores", {score_l, score_r}, 0);
    chk("rst_state", state, 0);
    chk("rst_color", color_index, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      x_addr = 12'(tbl[i].x); y_addr = 12'(tbl[i].y); bg = 8'(tbl[i].bg);
      @(negedge clk);
      chk($sformatf("overlay_%0d", i), color_index, tbl[i].exp);
    end

    // Serve: 60 ticks, exercising paddle clamps on the way
    for (int i = 0; i < 25; i++) begin
      do_tick(0, 1, 1, 1, 0, 0);
      if (i == 18) begin
        chk("pL_clamp19", pL_y, 0);
        chk("pR_untouched", pR_y, 190);
      end
    end
    chk("pL_hold0", pL_y, 0);
    for (int i = 0; i < 25; i++) do_tick(1, 1, 0, 1, 0, 0);
    chk("pR_clamp0", pR_y, 0);
    for (int i = 0; i < 9; i++) do_tick(1, 1, 1, 1, 0, 0);
    chk("serve_59", state, 0);
    do_tick(1, 1, 1, 1, 0, 0);
    chk("serve_60", state, 1);

    for (int k = 1; k <= 104; k++) begin
      do_tick(1, 1, 1, 1, 0, $urandom_range(0, 2));
      if (k == 1) begin
        chk("play1_x", ball_x, 313);
        chk("play1_y", ball_y, 233);
      end
      if (k == 77) chk("wall_bottom", ball_y, 460);
      if (k == 78) chk("wall_after", ball_y, 457);
      if (k == 104) begin
        chk("miss_score_l", score_l, 1);
        chk("miss_state", state, 0);
        chk("miss_x", ball_x, 310);
        chk("miss_y", ball_y, 230);
      end
    end

    for (int i = 0; i < 60; i++) do_tick(1, 1, 1, 1, 0, 0);
    chk("serve2", state, 1);
    for (int k = 1; k <= 64; k++) begin
      do_tick(1, 1, 1, 1, 0, 0);
      if (k == 63) chk("approach_x", ball_x, 121);
      if (k == 64) begin
        chk("hitL_x", ball_x, 120);
        chk("hitL_score_l", score_l, 1);
        chk("hitL_score_r", score_r, 0);
      end
    end
    n = 0;
    while (m_st != 2 && n < 400) begin
      do_tick(1, 1, 1, 1, 0, 0);
      n++;
    end
    chk("game_over", state, 2);
    chk("final_score_l", score_l, 2);
    for (int i = 0; i < 3; i++) do_tick(0, 1, 1, 0, 0, 0);

    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    m_reset();
    check_state();
    chk("restart_state", state, 0);
    chk("restart_score", {score_l, score_r}, 0);

    for (int i = 0; i < 2500; i++) begin
      bit rs;
      rs = ($urandom_range(0, 299) == 0) || (m_st == 2 && $urandom_range(0, 19) == 0);
      do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rs, $urandom_range(0, 2));
    end

    do_tick(1, 1, 1, 1, 1, 0);
    do_tick(0, 1, 1, 1, 0, 0);
    do_tick(0, 1, 1, 1, 0, 0);
    @(negedge clk);
    x_addr = 12'd310; y_addr = 12'd230; bg = 8'h05;
    @(negedge clk);
    chk("pre_reset_color", color_index, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pL_y", pL_y, 190);
    chk("async_color", color_index, 0);
    chk("async_state", state, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_tick(1, 0, 1, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
